// File: rtl/demux1to8_reg.sv
// -----------------------------------------------------------------------------
// demux1to8_reg
//
// Registered 1-to-8 demultiplexer with a per-channel valid/acknowledge
// handshake. One input word D is steered into one of eight held output
// registers (o1..o8). Each register has a sticky valid flag. The consumer of
// that channel clears the flag by pulsing its ack bit. When auto=1, an internal
// pointer supplies the target channel and advances on every accepted load.
//
// Optional feature (compile-time macro DEMUX_OVERRUN_EN):
//   defined   - A load to a channel that is still valid and not being acked
//               in that cycle is dropped. Both the data and ptr then hold,
//               and the sticky overrun flag is set.
//   undefined - Such a load simply overwrites the channel. overrun is tied 0.
//
// Ports:
//   clk            sole clock; all state changes on the rising edge
//   reset          synchronous, active-high reset (clears everything)
//   D   [WIDTH]    data word to distribute
//   S   [3]        channel select (0 -> o1 ... 7 -> o8), ignored when auto=1
//   load           write strobe
//   auto           1: target = ptr, 0: target = S
//   ack [8]        per-channel acknowledge; ack[k] clears valid[k]
//   clr            clears valid, ptr and overrun; data registers hold
//   o1..o8 [WIDTH] held channel data registers
//   valid [8]      sticky per-channel valid flags
//   ptr [3]        auto-mode pointer
//   full           &valid   (combinational from the valid register)
//   empty          ~|valid  (combinational from the valid register)
//   overrun        sticky overrun flag
// -----------------------------------------------------------------------------
module demux1to8_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] D,
  input  logic [2:0]       S,
  input  logic             load,
  input  logic             auto,
  input  logic [7:0]       ack,
  input  logic             clr,
  output logic [WIDTH-1:0] o1,
  output logic [WIDTH-1:0] o2,
  output logic [WIDTH-1:0] o3,
  output logic [WIDTH-1:0] o4,
  output logic [WIDTH-1:0] o5,
  output logic [WIDTH-1:0] o6,
  output logic [WIDTH-1:0] o7,
  output logic [WIDTH-1:0] o8,
  output logic [7:0]       valid,
  output logic [2:0]       ptr,
  output logic             full,
  output logic             empty,
  output logic             overrun
);

  logic [WIDTH-1:0] data_q [8];
  logic [WIDTH-1:0] data_d [8];
  logic [7:0]       valid_q, valid_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [2:0]       target;
  logic             accept;

`ifdef DEMUX_OVERRUN_EN
  logic             overrun_q, overrun_d;
  logic             is_overrun;
`endif

  always_comb begin
    // NOTE: every signal assigned in this block gets a default value first.
    // That way no path leaves a signal unassigned, so no latch is inferred.
    target  = auto ? ptr_q : S;
    data_d  = data_q;
    // Acks are applied first. A load to the same channel then overrides its
    // ack, so the load wins the collision.
    valid_d = valid_q & ~ack;
    ptr_d   = ptr_q;

`ifdef DEMUX_OVERRUN_EN
    // A load that is acked in the same cycle is not an overrun. The consumer
    // has just taken the old word.
    is_overrun = load & valid_q[target] & ~ack[target];
    accept     = load & ~is_overrun;
    overrun_d  = overrun_q;
`else
    accept     = load;
`endif

    if (clr) begin
      // clr outranks load and ack. The data registers deliberately hold.
      valid_d = '0;
      ptr_d   = '0;
`ifdef DEMUX_OVERRUN_EN
      overrun_d = 1'b0;
`endif
    end else begin
      if (accept) begin
        data_d[target]  = D;
        valid_d[target] = 1'b1;
        if (auto) begin
          ptr_d = ptr_q + 3'd1;  // wraps 7 -> 0 naturally
        end
      end
`ifdef DEMUX_OVERRUN_EN
      if (is_overrun) begin
        overrun_d = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    if (reset) begin
      // NOTE: the channel registers are part of the visible reset state
      // (o1..o8 read 0 after reset), so this storage is reset explicitly.
      // It is not left uninitialised the way a RAM would be.
      for (int i = 0; i < 8; i++) begin
        data_q[i] <= '0;
      end
      valid_q <= '0;
      ptr_q   <= '0;
`ifdef DEMUX_OVERRUN_EN
      overrun_q <= 1'b0;
`endif
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
`ifdef DEMUX_OVERRUN_EN
      overrun_q <= overrun_d;
`endif
    end
  end

  assign o1    = data_q[0];
  assign o2    = data_q[1];
  assign o3    = data_q[2];
  assign o4    = data_q[3];
  assign o5    = data_q[4];
  assign o6    = data_q[5];
  assign o7    = data_q[6];
  assign o8    = data_q[7];
  assign valid = valid_q;
  assign ptr   = ptr_q;
  assign full  = &valid_q;
  assign empty = ~|valid_q;

`ifdef DEMUX_OVERRUN_EN
  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_demux1to8_reg.sv
// -----------------------------------------------------------------------------
// tb_demux1to8_reg
//
// Testbench for demux1to8_reg with WIDTH=8. Directed scenarios compare the
// outputs against literal expected values. A randomized phase compares them
// against a behavioural model made of a channel array, a valid vector and a
// pointer. The same DEMUX_OVERRUN_EN setting as the RTL selects the overrun
// behaviour of the model.
// -----------------------------------------------------------------------------
module tb_demux1to8_reg;

  logic       clk = 1'b0;
  logic       reset, load, auto, clr;
  logic [7:0] D;
  logic [2:0] S;
  logic [7:0] ack;
  logic [7:0] o1, o2, o3, o4, o5, o6, o7, o8;
  logic [7:0] valid;
  logic [2:0] ptr;
  logic       full, empty, overrun;

  logic [7:0] o_arr [8];

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  logic [7:0] m_data [8];
  logic [7:0] m_valid;
  int         m_ptr;
  logic       m_ovr;

  demux1to8_reg #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .D(D), .S(S), .load(load), .auto(auto),
    .ack(ack), .clr(clr),
    .o1(o1), .o2(o2), .o3(o3), .o4(o4), .o5(o5), .o6(o6), .o7(o7), .o8(o8),
    .valid(valid), .ptr(ptr), .full(full), .empty(empty), .overrun(overrun)
  );

  assign o_arr[0] = o1;
  assign o_arr[1] = o2;
  assign o_arr[2] = o3;
  assign o_arr[3] = o4;
  assign o_arr[4] = o5;
  assign o_arr[5] = o6;
  assign o_arr[6] = o7;
  assign o_arr[7] = o8;

  always #5 clk = ~clk;

  // Apply the rules for one clock edge to the model. The rules are taken
  // directly from the channel behaviour.
  task automatic model_update();
    int  t;
    bit  busy;
    bit  drop;
`ifdef DEMUX_OVERRUN_EN
    drop = 1'b1;
`else
    drop = 1'b0;
`endif
    if (reset) begin
      for (int i = 0; i < 8; i++) m_data[i] = 8'h00;
      m_valid = 8'h00;
      m_ptr   = 0;
      m_ovr   = 1'b0;
    end else if (clr) begin
      m_valid = 8'h00;
      m_ptr   = 0;
      m_ovr   = 1'b0;
    end else begin
      t    = auto ? m_ptr : int'(S);
      busy = m_valid[t] && !ack[t];
      for (int k = 0; k < 8; k++) if (ack[k]) m_valid[k] = 1'b0;
      if (load) begin
        if (busy && drop) begin
          m_ovr = 1'b1;
        end else begin
          m_data[t]  = D;
          m_valid[t] = 1'b1;
          if (auto) m_ptr = (m_ptr + 1) % 8;
        end
      end
    end
  endtask

  // One clock edge: the model advances, then the outputs settle for sampling.
  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    reset = 1'b0; load = 1'b0; auto = 1'b0; clr = 1'b0;
    D = 8'h00; S = 3'd0; ack = 8'h00;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1; load = 1'b1; D = 8'hFF;
    tick();
    tick();
    idle_inputs();
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (o_arr[i] !== 8'h00) begin
        errors++;
        $display("FAIL reset_o%0d got %h expected 00", i + 1, o_arr[i]);
      end
    end
    checks++;
    if (valid !== 8'h00) begin
      errors++; $display("FAIL reset_valid got %h expected 00", valid);
    end
    checks++;
    if (ptr !== 3'd0) begin
      errors++; $display("FAIL reset_ptr got %0d expected 0", ptr);
    end
    checks++;
    if (empty !== 1'b1 || full !== 1'b0) begin
      errors++; $display("FAIL reset_flags got empty=%b full=%b expected 1 0", empty, full);
    end
    checks++;
    if (overrun !== 1'b0) begin
      errors++; $display("FAIL reset_overrun got %b expected 0", overrun);
    end
  endtask

  task automatic test_select();
    load = 1'b1; auto = 1'b0; D = 8'hA5; S = 3'd3;
    tick();
    D = 8'h3C; S = 3'd7;
    checks++;
    if (o4 !== 8'hA5 || valid !== 8'h08) begin
      errors++; $display("FAIL select_first got o4=%h valid=%h expected A5 08", o4, valid);
    end
    tick();
    load = 1'b0;
    checks++;
    if (o8 !== 8'h3C || valid !== 8'h88) begin
      errors++; $display("FAIL select_second got o8=%h valid=%h expected 3C 88", o8, valid);
    end
    checks++;
    if (o1 !== 8'h00 || o5 !== 8'h00 || ptr !== 3'd0) begin
      errors++; $display("FAIL select_others got o1=%h o5=%h ptr=%0d expected 00 00 0", o1, o5, ptr);
    end
  endtask

  task automatic test_auto_wrap();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    load = 1'b1; auto = 1'b1;
    for (int n = 1; n <= 9; n++) begin
      D = 8'(n);
      tick();
      if (n == 8) begin
        checks++;
        if (full !== 1'b1 || ptr !== 3'd0) begin
          errors++; $display("FAIL auto_full got full=%b ptr=%0d expected 1 0", full, ptr);
        end
      end
    end
    load = 1'b0; auto = 1'b0;
    for (int i = 1; i < 8; i++) begin
      checks++;
      if (o_arr[i] !== 8'(i + 1)) begin
        errors++; $display("FAIL auto_o%0d got %h expected %h", i + 1, o_arr[i], 8'(i + 1));
      end
    end
`ifdef DEMUX_OVERRUN_EN
    checks++;
    if (o1 !== 8'd1 || overrun !== 1'b1 || ptr !== 3'd0) begin
      errors++; $display("FAIL auto_wrap got o1=%h overrun=%b ptr=%0d expected 01 1 0", o1, overrun, ptr);
    end
`else
    checks++;
    if (o1 !== 8'd9 || overrun !== 1'b0 || ptr !== 3'd1) begin
      errors++; $display("FAIL auto_wrap got o1=%h overrun=%b ptr=%0d expected 09 0 1", o1, overrun, ptr);
    end
`endif
  endtask

  task automatic test_collision();
    // valid is 8'hFF here, so valid[2] is set.
    ack = 8'h04; load = 1'b1; auto = 1'b0; D = 8'h55; S = 3'd2;
    tick();
    load = 1'b0;
    checks++;
    if (valid !== 8'hFF || o3 !== 8'h55) begin
      errors++; $display("FAIL collision_load got valid=%h o3=%h expected FF 55", valid, o3);
    end
    tick();
    ack = 8'h00;
    checks++;
    if (valid !== 8'hFB) begin
      errors++; $display("FAIL collision_ack got valid=%h expected FB", valid);
    end
  endtask

  task automatic test_multi_ack();
    logic [7:0] snap [8];
    load = 1'b1; D = 8'h66; S = 3'd2;
    tick();
    load = 1'b0;
    checks++;
    if (valid !== 8'hFF) begin
      errors++; $display("FAIL multi_fill got valid=%h expected FF", valid);
    end
    for (int i = 0; i < 8; i++) snap[i] = m_data[i];
    ack = 8'h0F;
    tick();
    checks++;
    if (valid !== 8'hF0) begin
      errors++; $display("FAIL multi_ack_low got valid=%h expected F0", valid);
    end
    ack = 8'hF0;
    tick();
    ack = 8'h00;
    checks++;
    if (empty !== 1'b1 || valid !== 8'h00) begin
      errors++; $display("FAIL multi_ack_high got empty=%b valid=%h expected 1 00", empty, valid);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (o_arr[i] !== snap[i]) begin
        errors++; $display("FAIL multi_data_o%0d got %h expected %h", i + 1, o_arr[i], snap[i]);
      end
    end
  endtask

  task automatic test_clr();
    logic [7:0] o1_exp;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    load = 1'b1; auto = 1'b1;
    for (int n = 0; n < 5; n++) begin
      D = 8'h10 + 8'(n);
      tick();
    end
    auto = 1'b0; load = 1'b0; ack = 8'h1E;
    tick();
    ack = 8'h00; load = 1'b1; D = 8'h99; S = 3'd7;
    tick();
    // Load to a still-valid channel 0 without ack.
    D = 8'hEE; S = 3'd0;
    tick();
    load = 1'b0;
`ifdef DEMUX_OVERRUN_EN
    o1_exp = 8'h10;
    checks++;
    if (overrun !== 1'b1 || o1 !== 8'h10) begin
      errors++; $display("FAIL overrun_set got overrun=%b o1=%h expected 1 10", overrun, o1);
    end
`else
    o1_exp = 8'hEE;
`endif
    checks++;
    if (valid !== 8'h81 || ptr !== 3'd5) begin
      errors++; $display("FAIL clr_setup got valid=%h ptr=%0d expected 81 5", valid, ptr);
    end
    clr = 1'b1; load = 1'b1; D = 8'h77; S = 3'd0;
    tick();
    clr = 1'b0; load = 1'b0;
    checks++;
    if (valid !== 8'h00 || ptr !== 3'd0 || overrun !== 1'b0) begin
      errors++; $display("FAIL clr_flags got valid=%h ptr=%0d overrun=%b expected 00 0 0", valid, ptr, overrun);
    end
    checks++;
    if (o1 !== o1_exp) begin
      errors++; $display("FAIL clr_o1 got %h expected %h", o1, o1_exp);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset = ($urandom_range(0, 99) == 0);
      clr   = ($urandom_range(0, 39) == 0);
      load  = ($urandom_range(0, 2) != 0);
      auto  = ($urandom_range(0, 1) == 1);
      D     = 8'($urandom);
      S     = 3'($urandom);
      ack   = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      tick();
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (o_arr[i] !== m_data[i]) begin
          errors++; $display("FAIL rand_o%0d cycle %0d got %h expected %h", i + 1, c, o_arr[i], m_data[i]);
        end
      end
      checks++;
      if (valid !== m_valid || ptr !== 3'(m_ptr) || overrun !== m_ovr) begin
        errors++;
        $display("FAIL rand_state cycle %0d got valid=%h ptr=%0d ovr=%b expected %h %0d %b",
                 c, valid, ptr, overrun, m_valid, m_ptr, m_ovr);
      end
      checks++;
      if (full !== (m_valid == 8'hFF) || empty !== (m_valid == 8'h00)) begin
        errors++; $display("FAIL rand_flags cycle %0d got full=%b empty=%b", c, full, empty);
      end
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m_data[i] = 8'h00;
    m_valid = 8'h00;
    m_ptr   = 0;
    m_ovr   = 1'b0;
    idle_inputs();
    #2;
    test_reset();
    test_select();
    test_auto_wrap();
    test_collision();
    test_multi_ack();
    test_clr();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux1to8_reg.md
# demux1to8_reg

Registered 1-to-8 demultiplexer with per-channel valid/acknowledge handshake. It is the distribution counterpart of the processor's 8-to-1 selection path: one input word is steered to one of eight held output registers. Each output register carries a sticky valid flag that its consumer clears by acknowledging. An optional auto-increment pointer lets a producer fill channels in sequence without driving a select code.

## Interface
Parameters:
- WIDTH, 8, data word width of D and of each output register o1..o8.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- D  input  WIDTH  data word to distribute.
- S  input  3  channel select; S=0 targets o1, S=7 targets o8. Ignored when auto=1.
- load  input  1  write strobe; writes D to the target channel this cycle.
- auto  input  1  1 = target is the internal pointer ptr; 0 = target is S.
- ack  input  8  per-channel acknowledge; ack[k] clears valid[k], targeting channel o(k+1).
- clr  input  1  clears all valid flags, ptr and overrun. Data registers are unchanged.
- o1..o8  output  WIDTH each  held channel data registers.
- valid  output  8  sticky per-channel valid flags.
- ptr  output  3  auto-mode pointer.
- full  output  1  &valid (combinational).
- empty  output  1  ~|valid (combinational).
- overrun  output  1  sticky overrun flag; constant 0 unless DEMUX_OVERRUN_EN is defined.

## Operation
- Target index: t = auto ? ptr : S.
- Priority order: reset > clr > load/ack.
- Reset: o1..o8 = 0, valid = 0, ptr = 0, overrun = 0.
- clr=1:
  - valid <= 0, ptr <= 0, overrun <= 0.
  - Any load in the same cycle is ignored; o1..o8 hold.
- Accepted load:
  - o(t+1) <= D and valid[t] <= 1.
  - If auto=1, ptr <= ptr+1, wrapping 7 -> 0.
  - If auto=0, ptr holds.
- Ack: for each k with ack[k]=1, valid[k] <= 0. Acks to several channels in one cycle are all applied.
- Simultaneous ack[t] and accepted load to t: the load wins; valid[t] stays 1 and the data is updated.
- Ack to a channel whose valid is 0 has no effect.
- Overrun: a load to t while valid[t]=1 and ack[t]=0. Handling depends on DEMUX_OVERRUN_EN (see Configuration).
- Only the targeted register changes on a load. All other channels hold data and valid.

## Timing
- Write latency is 1 cycle: load sampled at edge n gives o/valid updated after edge n, visible in cycle n+1.
- Ack latency is 1 cycle.
- full and empty are combinational from the valid register, so they also lag load/ack by 1 cycle.
- ptr advances on the same edge that accepts the auto-mode load.
- reset or clr asserted mid-stream takes effect on that edge. A load presented in the same cycle is lost.
- There is no combinational path from D, S or load to any output.

## Configuration
- Macro: DEMUX_OVERRUN_EN.
- Defined:
  - An overrunning load is dropped: o(t+1) unchanged and ptr not advanced.
  - overrun <= 1, held until clr or reset.
- Undefined:
  - An overrunning load overwrites o(t+1) (valid stays 1) and advances ptr in auto mode.
  - overrun is tied 0 and no detection logic is built.

## Test plan
- Reset: assert reset 2 cycles with load=1, D=8'hFF. Then o1..o8=0, valid=8'h00, ptr=0, empty=1, full=0, overrun=0.
- Select mode: auto=0; load D=8'hA5,S=3 then D=8'h3C,S=7. Result: o4=8'hA5, o8=8'h3C, valid=8'h88, each 1 cycle after its load. Other channels stay 0 and ptr stays 0.
- Auto mode and wrap: auto=1; 9 consecutive loads D=1..9. Result: o1..o8=1..8 and full=1 after the 8th load. The 9th load targets o1:
  - with DEMUX_OVERRUN_EN: o1 stays 1, overrun=1, ptr=0.
  - without: o1=9, ptr=1, overrun=0.
- Load/ack collision: valid[2]=1; same cycle ack=8'h04 and load D=8'h55,S=2. Result: valid[2]=1, o3=8'h55. Next cycle ack=8'h04 alone gives valid[2]=0.
- Multi-ack: valid=8'hFF; ack=8'h0F gives valid=8'hF0, then ack=8'hF0 gives empty=1. Data registers are unchanged throughout.
- clr priority: clr=1 with load D=8'h77,S=0, valid=8'h81, ptr=5, overrun=1. Result: valid=0, ptr=0, overrun=0, o1 unchanged (not 8'h77).
